// File: rtl/pong_pkg.sv
// Shared types and defaults for the Pong game sequencer.
package pong_pkg;

  localparam int unsigned DEF_LIVES       = 3;
  localparam int unsigned DEF_WAIT_FRAMES = 120;
  localparam int unsigned BCD_W           = 4;

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

endpackage

// File: rtl/pong_game_ctrl_bcd2_counter.sv
// Two-digit BCD counter that saturates at 99; clr returns it to 00.
module bcd2_counter
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] hi,
  output logic [BCD_W-1:0] lo
);

  logic at_max;

  assign at_max = (hi == BCD_W'(9)) && (lo == BCD_W'(9));

  // Count with decimal carry from ones into tens; hold at 99.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      hi <= '0;
      lo <= '0;
    end else if (inc && !at_max) begin
      if (lo == BCD_W'(9)) begin
        lo <= '0;
        hi <= hi + BCD_W'(1);
      end else begin
        lo <= lo + BCD_W'(1);
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/freeze control, lives, BCD score, pause timer.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned LIVES       = DEF_LIVES,
  parameter int unsigned WAIT_FRAMES = DEF_WAIT_FRAMES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       btn,
  input  logic             refresh_tick,
  input  logic             hit,
  input  logic             miss,
  output logic             graph_still,
  output logic             ball_reset,
  output logic [1:0]       lives,
  output logic [BCD_W-1:0] score_hi,
  output logic [BCD_W-1:0] score_lo,
  output logic             game_over
);

  localparam int unsigned TIMER_W = $clog2(WAIT_FRAMES + 1);

  state_t               state, state_nx;
  logic [TIMER_W-1:0]   timer, timer_nx;
  logic [1:0]           lives_nx;
  logic [1:0]           btn_q;
  logic                 start_req;
  logic                 score_inc, score_clr;
  logic                 graph_still_nx, ball_reset_nx, game_over_nx;

  // Rising edge of any button; a held button starts nothing further.
  assign start_req = (|btn) & ~(|btn_q);

  // State, timer, lives and output flag registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= NEWGAME;
      timer       <= '0;
      lives       <= 2'(LIVES);
      btn_q       <= '0;
      graph_still <= 1'b1;
      ball_reset  <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      lives       <= lives_nx;
      btn_q       <= btn;
      graph_still <= graph_still_nx;
      ball_reset  <= ball_reset_nx;
      game_over   <= game_over_nx;
    end
  end

  // Next-state, timer, lives and score control; flags decode the next state
  // so they move on the same edge as the state register.
  always_comb begin
    state_nx  = state;
    timer_nx  = timer;
    lives_nx  = lives;
    score_inc = 1'b0;
    score_clr = 1'b0;

    case (state)
      NEWGAME: begin
        if (start_req) state_nx = PLAY;
      end
      PLAY: begin
        if (miss) begin
          timer_nx = TIMER_W'(WAIT_FRAMES);
          if (lives == 2'd1) begin
            lives_nx = 2'd0;
            state_nx = OVER;
          end else begin
            lives_nx = lives - 2'd1;
            state_nx = NEWBALL;
          end
        end else if (hit) begin
          score_inc = 1'b1;
        end
      end
      NEWBALL: begin
        if (timer == '0) begin
          if (start_req) state_nx = PLAY;
        end else if (refresh_tick) begin
          timer_nx = timer - TIMER_W'(1);
        end
      end
      OVER: begin
        if (timer == '0) begin
          state_nx  = NEWGAME;
          lives_nx  = 2'(LIVES);
          score_clr = 1'b1;
        end else if (refresh_tick) begin
          timer_nx = timer - TIMER_W'(1);
        end
      end
      default: state_nx = NEWGAME;
    endcase

    graph_still_nx = (state_nx != PLAY);
    ball_reset_nx  = (state_nx != PLAY);
    game_over_nx   = (state_nx == OVER);
  end

  // Score keeper; its own reset covers rst, clr covers the game-over reload.
  bcd2_counter u_score (
    .clk (clk),
    .rst (rst),
    .inc (score_inc),
    .clr (score_clr),
    .hi  (score_hi),
    .lo  (score_lo)
  );

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: a behavioural model predicts the
// outputs of every edge when inputs are driven; a monitor compares after it.
module tb_pong_game_ctrl;

  localparam int M_NEWGAME = 0;
  localparam int M_PLAY    = 1;
  localparam int M_NEWBALL = 2;
  localparam int M_OVER    = 3;
  localparam int N_LIVES   = 3;
  localparam int N_WAIT    = 120;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn;
  logic       refresh_tick, hit, miss;
  logic       graph_still, ball_reset, game_over;
  logic [1:0] lives;
  logic [3:0] score_hi, score_lo;

  always #5 clk = ~clk;

  pong_game_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .refresh_tick (refresh_tick),
    .hit          (hit),
    .miss         (miss),
    .graph_still  (graph_still),
    .ball_reset   (ball_reset),
    .lives        (lives),
    .score_hi     (score_hi),
    .score_lo     (score_lo),
    .game_over    (game_over)
  );

  typedef struct {
    string tag;
    int    gs;
    int    br;
    int    lv;
    int    hi;
    int    lo;
    int    go;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state (decimal score, integer timer).
  int         m_state = M_NEWGAME;
  int         m_lives = N_LIVES;
  int         m_score = 0;
  int         m_timer = 0;
  logic [1:0] m_btnq  = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, queue the predicted outputs.
  task automatic drive(input bit r, input logic [1:0] b, input bit t,
                       input bit h, input bit m, input string tag);
    exp_t e;
    bit   start;
    rst = r; btn = b; refresh_tick = t; hit = h; miss = m;
    start = (b != 2'b00) && (m_btnq == 2'b00);
    if (!r) begin
      m_state = M_NEWGAME; m_lives = N_LIVES; m_score = 0; m_timer = 0; m_btnq = 2'b00;
    end else begin
      m_btnq = b;
      case (m_state)
        M_NEWGAME: if (start) m_state = M_PLAY;
        M_PLAY: begin
          if (m) begin
            m_lives = m_lives - 1;
            m_timer = N_WAIT;
            m_state = (m_lives == 0) ? M_OVER : M_NEWBALL;
          end else if (h) begin
            m_score = (m_score >= 99) ? 99 : m_score + 1;
          end
        end
        M_NEWBALL: begin
          if (m_timer == 0) begin
            if (start) m_state = M_PLAY;
          end else if (t) m_timer = m_timer - 1;
        end
        default: begin
          if (m_timer == 0) begin
            m_state = M_NEWGAME; m_lives = N_LIVES; m_score = 0;
          end else if (t) m_timer = m_timer - 1;
        end
      endcase
    end
    e.tag = tag;
    e.gs  = (m_state != M_PLAY) ? 1 : 0;
    e.br  = (m_state != M_PLAY) ? 1 : 0;
    e.go  = (m_state == M_OVER) ? 1 : 0;
    e.lv  = m_lives;
    e.hi  = m_score / 10;
    e.lo  = m_score % 10;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Compare DUT outputs just after each edge against the queued prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({e.tag, ".graph_still"}, 32'(graph_still), 32'(e.gs));
      check({e.tag, ".ball_reset"},  32'(ball_reset),  32'(e.br));
      check({e.tag, ".lives"},       32'(lives),       32'(e.lv));
      check({e.tag, ".score_hi"},    32'(score_hi),    32'(e.hi));
      check({e.tag, ".score_lo"},    32'(score_lo),    32'(e.lo));
      check({e.tag, ".game_over"},   32'(game_over),   32'(e.go));
    end
  end

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0, tag);
      drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, tag);
    end
  endtask

  task automatic press(input logic [1:0] b, input string tag);
    drive(1'b1, b, 1'b0, 1'b0, 1'b0, tag);
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic hits(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, tag);
      drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, tag);
    end
  endtask

  task automatic do_miss(input string tag);
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b1, tag);
  endtask

  initial begin
    rst = 1'b0; btn = 2'b00; refresh_tick = 1'b0; hit = 1'b0; miss = 1'b0;

    // Reset and start
    for (int i = 0; i < 3; i++) drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, "reset");
    check("reset_lives", 32'(lives), 32'd3);
    check("reset_score", 32'({score_hi, score_lo}), 32'h00);
    idle(2, "newgame_idle");
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, "start");
    check("start_play", 32'(graph_still), 32'd0);
    for (int i = 0; i < 10; i++) drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, "btn_held");
    idle(1, "btn_release");

    // Scoring with carry and saturation
    hits(12, "hits12");
    check("score_12", 32'({score_hi, score_lo}), 32'h12);
    hits(86, "hits98");
    check("score_98", 32'({score_hi, score_lo}), 32'h98);
    hits(2, "hits99");
    check("score_99", 32'({score_hi, score_lo}), 32'h99);
    hits(1, "hit_sat");
    check("score_sat", 32'({score_hi, score_lo}), 32'h99);

    // Miss, early press ignored, serve after the full pause
    do_miss("miss1");
    check("miss1_lives", 32'(lives), 32'd2);
    ticks(50, "wait50");
    press(2'b10, "early_press");
    check("early_still", 32'(graph_still), 32'd1);
    ticks(70, "wait120");
    press(2'b01, "serve1");
    check("serve1_play", 32'(ball_reset), 32'd0);

    // Two more misses to game over, then the pause back to a new game
    do_miss("miss2");
    ticks(120, "wait_m2");
    press(2'b11, "serve2");
    hits(3, "hits_m3");
    do_miss("miss3");
    check("over_flag", 32'(game_over), 32'd1);
    check("over_lives", 32'(lives), 32'd0);
    ticks(120, "over_wait");
    idle(2, "over_exit");
    check("newgame_lives", 32'(lives), 32'd3);
    check("newgame_score", 32'({score_hi, score_lo}), 32'h00);
    check("newgame_go", 32'(game_over), 32'd0);

    // Simultaneous hit and miss at score 05, lives 2
    press(2'b01, "start2");
    do_miss("miss_a");
    ticks(120, "wait_a");
    press(2'b01, "serve_a");
    hits(5, "hits5");
    drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, "hit_miss");
    check("hm_score", 32'({score_hi, score_lo}), 32'h05);
    check("hm_lives", 32'(lives), 32'd1);
    check("hm_still", 32'(graph_still), 32'd1);

    // Reset in the middle of the countdown, then a stray hit in NEWGAME
    ticks(60, "wait60");
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, "mid_reset");
    check("midrst_lives", 32'(lives), 32'd3);
    check("midrst_score", 32'({score_hi, score_lo}), 32'h00);
    drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, "newgame_hit");
    idle(2, "tail");
    check("newgame_hit_score", 32'({score_hi, score_lo}), 32'h00);
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Top-level game sequencer for the FPGA Pong design. Decides when the ball/paddle graphics engine runs or freezes, when the ball is re-served, and tracks remaining balls and the two-digit BCD score. Sits between the button inputs, the per-frame refresh tick from the VGA sync block, and the graphics/text generators that produce rgb.

Parameters:
LIVES, 3, balls per game (1..3, fits 2-bit lives output)
WAIT_FRAMES, 120, frames (~2 s at 60 Hz) of enforced pause after a miss or game over

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
btn  in  2  player buttons, synchronous and debounced upstream
refresh_tick  in  1  one-clk pulse per frame, from vsync logic
hit  in  1  one-clk pulse: ball struck paddle
miss  in  1  one-clk pulse: ball passed paddle
graph_still  out  1  1 = graphics engine frozen
ball_reset  out  1  1 = graphics engine reloads ball to serve position
lives  out  2  balls remaining
score_hi  out  4  BCD tens digit
score_lo  out  4  BCD ones digit
game_over  out  1  1 while the OVER state is active

Behaviour:
- All outputs registered; all state changes on posedge clk; rst sampled only on clk edge (rst==0 -> reset).
- Reset values: state=NEWGAME, graph_still=1, ball_reset=1, lives=LIVES, score=00, game_over=0, timer=0, btn_q=0.
- start_req = (|btn) & ~(|btn_q); btn_q registers btn every cycle. Level-held buttons never re-trigger.
- States:
  NEWGAME: graph_still=1, ball_reset=1. start_req -> PLAY.
  PLAY: graph_still=0, ball_reset=0. hit -> score+1. miss -> if lives==1: lives=0, timer=WAIT_FRAMES, -> OVER; else lives-1, timer=WAIT_FRAMES, -> NEWBALL.
  NEWBALL: graph_still=1, ball_reset=1. refresh_tick & timer!=0 -> timer-1. timer==0 & start_req -> PLAY. start_req while timer!=0 is ignored.
  OVER: graph_still=1, ball_reset=1, game_over=1. refresh_tick & timer!=0 -> timer-1. timer==0 -> NEWGAME, with lives=LIVES and score=00 loaded on the same edge.
- Latency: hit/miss in cycle n -> score/lives/state updated and visible at n+1. Output flags follow the registered state, so they change in the same cycle as the state.
- Score: two-digit BCD. Ones digit 9 -> 0 with carry into tens. 99 saturates (a hit at 99 leaves 99).
- hit and miss in the same cycle: miss wins and score is unchanged.
- hit or miss outside PLAY: ignored.
- refresh_tick is counted only in NEWBALL/OVER.
- Timer width = $clog2(WAIT_FRAMES+1). Decrement saturates at 0.
- rst asserted in any state, including mid-countdown: full reset on the next edge. Pending pulses are dropped.

Decomposition:
- Package pong_pkg: state encoding (NEWGAME=2'b00, PLAY=2'b01, NEWBALL=2'b10, OVER=2'b11), default LIVES/WAIT_FRAMES constants, BCD digit width.
- One sub-module bcd2_counter, a two-digit saturating BCD counter with inc and clr inputs and synchronous active-low rst. FSM and timer stay in pong_game_ctrl.

Test Plan:
- Reset and start: hold rst=0 for 3 clks -> lives=3, score=00, graph_still=1, ball_reset=1. Pulse btn=2'b01 -> PLAY next clk, graph_still=0. Hold btn 10 clks -> no further transitions.
- Scoring: in PLAY, 12 hit pulses -> score_hi=1, score_lo=2. Preload 98 with two more hits -> 99, and a 3rd hit stays 99.
- Miss and re-serve: miss in PLAY -> lives 3->2, NEWBALL, graph_still=1. btn pressed after 50 refresh_ticks -> stays NEWBALL. btn after 120 ticks -> PLAY.
- Game over: three misses with serves in between -> lives=0, game_over=1. After 120 refresh_ticks -> NEWGAME, lives=3, score=00, game_over=0.
- Simultaneous hit+miss at score 05, lives 2 -> score stays 05, lives=1, NEWBALL.
- Mid-countdown reset: rst=0 at timer=60 in NEWBALL -> NEWGAME defaults on the next clk. A hit pulsed in NEWGAME leaves score=00.
